// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci job scheduler.
package fib_pkg;

  localparam int FIB_W  = 16;
  localparam int FIB_CW = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fib_state_t;

  // Wide sum with carry; callers truncate to W+1 bits so bit W is the carry.
  function automatic logic [64:0] fib_add(input logic [63:0] x, input logic [63:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/fib_step.sv
// Fibonacci term datapath: holds the current/next terms and their wrap flags.
module fib_step
  import fib_pkg::*;
#(
  parameter int W = FIB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] seed_a,
  input  logic [W-1:0] seed_b,
  output logic [W-1:0] a,
  output logic         ovf_a
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_ovf_a;
  logic         r_ovf_b;
  logic [W:0]   w_sum;

  assign w_sum = (W+1)'(fib_add(64'(r_a), 64'(r_b)));

  // A term is flagged once any addition earlier in its chain has wrapped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_ovf_a <= 1'b0;
      r_ovf_b <= 1'b0;
    end else if (load) begin
      r_a     <= seed_a;
      r_b     <= seed_b;
      r_ovf_a <= 1'b0;
      r_ovf_b <= 1'b0;
    end else if (advance) begin
      r_a     <= r_b;
      r_b     <= w_sum[W-1:0];
      r_ovf_a <= r_ovf_b;
      r_ovf_b <= r_ovf_a | r_ovf_b | w_sum[W];
    end
  end

  assign a     = r_a;
  assign ovf_a = r_ovf_a;

endmodule

// File: rtl/fib_job_scheduler.sv
// Round-robin scheduler sharing one Fibonacci engine between two requesters,
// streaming each job's terms over a valid/ready output.
module fib_job_scheduler
  import fib_pkg::*;
#(
  parameter int W  = FIB_W,
  parameter int CW = FIB_CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*CW-1:0] req_count,
  input  logic [2*W-1:0]  req_seed_a,
  input  logic [2*W-1:0]  req_seed_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_id,
  output logic            out_last,
  output logic            out_ovf,
  output logic            busy
);

  fib_state_t    r_state;
  logic          r_ptr;
  logic          r_id;
  logic [CW-1:0] r_rem;

  logic          w_g;
  logic          w_accept;
  logic          w_xfer;
  logic          w_run;
  logic [CW-1:0] w_count;
  logic [W-1:0]  w_seed_a;
  logic [W-1:0]  w_seed_b;
  logic [W-1:0]  w_a;
  logic          w_ovf_a;

  assign w_run    = (r_state == RUN);
  assign w_g      = req_valid[r_ptr] ? r_ptr : ~r_ptr;
  assign w_accept = !w_run && (|req_valid);
  assign w_xfer   = w_run && out_ready;

  assign w_count  = w_g ? req_count[2*CW-1:CW] : req_count[CW-1:0];
  assign w_seed_a = w_g ? req_seed_a[2*W-1:W]  : req_seed_a[W-1:0];
  assign w_seed_b = w_g ? req_seed_b[2*W-1:W]  : req_seed_b[W-1:0];

  assign req_ready = w_accept ? (w_g ? 2'b10 : 2'b01) : 2'b00;

  // A RUN job that ends returns to IDLE first, so no accept overlaps its last term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_rem   <= w_count;
      r_id    <= w_g;
      r_ptr   <= ~w_g;
      r_state <= (w_count != '0) ? RUN : IDLE;
    end else if (w_xfer) begin
      r_rem <= r_rem - 1'b1;
      if (r_rem == CW'(1)) r_state <= IDLE;
    end
  end

  fib_step #(
    .W(W)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .advance(w_xfer),
    .seed_a (w_seed_a),
    .seed_b (w_seed_b),
    .a      (w_a),
    .ovf_a  (w_ovf_a)
  );

  assign busy      = w_run;
  assign out_valid = w_run;
  assign out_data  = w_run ? w_a : '0;
  assign out_id    = w_run & r_id;
  assign out_ovf   = w_run & w_ovf_a;
  assign out_last  = w_run && (r_rem == CW'(1));

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Directed bench with scoreboards for a 16-bit and an 8-bit scheduler instance.
module tb_fib_job_scheduler;

  typedef struct packed {
    logic [15:0] data;
    logic        id;
    logic        last;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  rv, rr;
  logic [15:0] rc;
  logic [31:0] ia, ib;
  logic        ov, ordy, oid, olast, oovf, bsy;
  logic [15:0] od;

  logic [1:0]  rv8, rr8;
  logic [15:0] rc8, ia8, ib8;
  logic        ov8, ordy8, oid8, olast8, oovf8, bsy8;
  logic [7:0]  od8;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t q8[$];

  fib_job_scheduler #(.W(16), .CW(8)) dut16 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rr), .req_count(rc),
    .req_seed_a(ia), .req_seed_b(ib), .out_valid(ov), .out_ready(ordy),
    .out_data(od), .out_id(oid), .out_last(olast), .out_ovf(oovf), .busy(bsy)
  );

  fib_job_scheduler #(.W(8), .CW(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(rv8), .req_ready(rr8), .req_count(rc8),
    .req_seed_a(ia8), .req_seed_b(ib8), .out_valid(ov8), .out_ready(ordy8),
    .out_data(od8), .out_id(oid8), .out_last(olast8), .out_ovf(oovf8), .busy(bsy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_job(input bit to8, input int id, input int sa, input int sb,
                          input int n, input int w);
    longint x, y, s;
    bit     ox, oy, c, t;
    exp_t   e;
    x = sa; y = sb; ox = 1'b0; oy = 1'b0;
    for (int k = 0; k < n; k++) begin
      e.data = 16'(x);
      e.id   = id[0];
      e.last = (k == n - 1);
      e.ovf  = ox;
      if (to8) q8.push_back(e);
      else     q.push_back(e);
      s  = x + y;
      c  = s[w];
      x  = y;
      y  = s & ((64'd1 << w) - 1);
      t  = ox | oy | c;
      ox = oy;
      oy = t;
    end
  endtask

  always @(negedge clk) begin
    exp_t e, g;
    if (!rst && ov && ordy) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL d16_extra got=%0h exp=none", od);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        g = '{od, oid, olast, oovf};
        chk("d16_term", 32'(g), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e, g;
    if (!rst && ov8 && ordy8) begin
      total++;
      assert (q8.size() != 0) else begin
        bad++;
        $error("FAIL d8_extra got=%0h exp=none", od8);
      end
      if (q8.size() != 0) begin
        e = q8.pop_front();
        g = '{{8'h00, od8}, oid8, olast8, oovf8};
        chk("d8_term", 32'(g), 32'(e));
      end
    end
  end

  task automatic submit16(input int id, input int sa, input int sb, input int n);
    @(posedge clk); #1;
    rv[id]            = 1'b1;
    rc[id*8 +: 8]     = 8'(n);
    ia[id*16 +: 16]   = 16'(sa);
    ib[id*16 +: 16]   = 16'(sb);
    push_job(1'b0, id, sa, sb, n, 16);
    @(negedge clk);
    chk("req_ready", 32'(rr), 32'(1 << id));
    @(posedge clk); #1;
    rv[id] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || q8.size() != 0 || bsy || bsy8) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_data(input logic [15:0] v, input string tag);
    int n;
    bit hit;
    hit = 1'b0;
    for (n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      if (ov && od == v) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    bit hit;
    rv = '0; rc = '0; ia = '0; ib = '0; ordy = 1'b1;
    rv8 = '0; rc8 = '0; ia8 = '0; ib8 = '0; ordy8 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_ready", 32'(rr), 0);
    chk("rst_busy",  32'(bsy), 0);
    chk("rst_data",  32'(od), 0);
    chk("rst_flags", 32'({oid, olast, oovf}), 0);

    // Contention straight out of reset
    @(posedge clk); #1;
    rst = 1'b0;
    rv  = 2'b11;
    rc  = {8'd2, 8'd3};
    ia  = {16'd2, 16'd0};
    ib  = {16'd3, 16'd1};
    push_job(1'b0, 0, 0, 1, 3, 16);
    push_job(1'b0, 1, 2, 3, 2, 16);
    @(negedge clk);
    chk("cont_ready0", 32'(rr), 32'b01);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(negedge clk);
    chk("run_ready", 32'(rr), 0);
    chk("run_busy",  32'(bsy), 1);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      if (rr == 2'b10) hit = 1'b1;
    end
    chk("cont_ready1", 32'(hit), 1);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    drain("cont");

    // Single job with continuous out_ready
    submit16(0, 1, 1, 10);
    drain("single");

    // Backpressure while 5 is presented
    submit16(0, 1, 1, 10);
    wait_data(16'd3, "bp_find3");
    @(posedge clk); #1;
    ordy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data",  32'(od), 5);
      chk("bp_hold_valid", 32'(ov), 1);
    end
    @(posedge clk); #1;
    ordy = 1'b1;
    drain("bp");

    // Zero-count job from requester 1 moves the pointer back to 0
    submit16(1, 7, 7, 0);
    @(negedge clk);
    chk("zero_valid", 32'(ov), 0);
    chk("zero_busy",  32'(bsy), 0);
    chk("zero_ready", 32'(rr), 0);
    rv = 2'b11;
    #1;
    chk("zero_ptr", 32'(rr), 32'b01);
    rv = 2'b00;

    // Reset in the middle of a job
    submit16(0, 1, 1, 10);
    wait_data(16'd5, "mr_find5");
    @(posedge clk); #1;
    chk("mr_pre_data", 32'(od), 8);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(ov), 0);
    chk("mr_busy",  32'(bsy), 0);
    chk("mr_data",  32'(od), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    submit16(0, 1, 1, 2);
    drain("mr_restart");

    // Wrap detection on the 8-bit instance
    @(posedge clk); #1;
    rv8 = 2'b01;
    rc8[7:0] = 8'd14;
    ia8[7:0] = 8'd1;
    ib8[7:0] = 8'd1;
    push_job(1'b1, 0, 1, 1, 14, 8);
    @(posedge clk); #1;
    rv8 = 2'b00;
    drain("ovf8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_job_scheduler.md
Name: fib_job_scheduler

Overview:
- Shares one iterative Fibonacci term engine between two requesters.
- Each requester submits a job: two seed terms and a term count.
- A round-robin arbiter grants one job at a time. The engine then streams the job's terms over a valid/ready output, tagged with the requester id, with last and overflow flags.
- Sits between sequence-consuming blocks and the Fibonacci datapath. It replaces the free-running, reset-triggered generation style with a controlled, back-pressured service.

Parameters:
- W, 16, term width in bits; all arithmetic is modulo 2^W.
- CW, 8, job count width in bits; a job holds at most 2^CW-1 terms.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  2  per-requester job request (bit i = requester i).
- req_ready  output  2  per-requester accept strobe; one-hot or zero.
- req_count  input  2*CW  job term counts; bits [i*CW +: CW] belong to requester i.
- req_seed_a  input  2*W  first seed per requester.
- req_seed_b  input  2*W  second seed per requester.
- out_valid  output  1  out_data holds a valid term.
- out_ready  input  1  consumer accepts the term.
- out_data  output  W  current term.
- out_id  output  1  requester that owns the current job.
- out_last  output  1  current term is the final term of the job.
- out_ovf  output  1  current term is the result of a wrapped addition chain.
- busy  output  1  a job is in progress (state RUN).

Behaviour:
- Reset values: state IDLE; out_valid=0, req_ready=0, busy=0; out_data=0, out_id=0, out_last=0, out_ovf=0; rr pointer=0; remaining=0. Reset takes effect immediately, including mid-job; the in-flight job is discarded and never resumed.
- FSM has two states, IDLE and RUN.
- IDLE, arbitration:
  - g = pointer if req_valid[pointer], else the other requester if its req_valid is set.
  - req_ready[g] is asserted combinationally in IDLE only. A job is accepted on req_valid[g] && req_ready[g].
- On accept:
  - Load a=seed_a[g], b=seed_b[g], remaining=count[g], id=g; clear ovf_a and ovf_b.
  - Set pointer = ~g.
  - If count[g]==0, stay in IDLE (the job completes with no output). Otherwise go to RUN next cycle.
  - No new job can be accepted in the same cycle that a RUN job ends.
- RUN, outputs:
  - out_valid=1, out_data=a, out_id=id, out_ovf=ovf_a, out_last=(remaining==1).
  - First term appears 1 cycle after accept.
- RUN, on out_valid && out_ready:
  - a <= b, b <= a+b truncated to W bits, remaining <= remaining-1.
  - ovf_a <= ovf_b; ovf_b <= ovf_a | ovf_b | carry(a+b).
  - If remaining==1, go to IDLE; out_valid is 0 the next cycle.
- RUN, out_ready low: all outputs hold stable. out_valid never drops without a transfer, except on reset.
- Throughput: 1 term per cycle under continuous out_ready.
- Requester inputs are sampled only at accept; changes during RUN have no effect.
- Both requesters valid with pointer=0: requester 0 is served first, then requester 1. Strict alternation under continuous contention.
- busy=1 exactly in RUN.

Decomposition:
- Package fib_pkg holds:
  - state enum {IDLE, RUN};
  - default constants FIB_W=16, FIB_CW=8;
  - a helper function for next-term sum with carry out.
- Sub-module fib_step holds the datapath only:
  - registers a, b, ovf_a, ovf_b;
  - inputs load, seeds, advance;
  - outputs a and ovf_a.
- fib_job_scheduler keeps the arbiter, FSM and counter.

Test Plan:
- Single job, W=16: requester 0 submits seeds 1,1, count 10, out_ready=1 → out_data 1,1,2,3,5,8,13,21,34,55 on consecutive cycles; out_last only on 55; out_id=0; out_ovf=0.
- Contention: both requesters valid after reset. Req0 submits seeds 0,1 count 3; req1 submits seeds 2,3 count 2 → req0 granted first, streams 0,1,1; then req1 granted, streams 2,3 with out_id=1.
- Backpressure: during the seeds 1,1 job, drop out_ready for 3 cycles while out_data=5 → 5 holds stable with out_valid=1; sequence resumes 8,13 with no term lost or duplicated.
- Overflow, W=8: seeds 1,1, count 14 → term 13 = 233 with out_ovf=0; term 14 = 121 (377 mod 256) with out_ovf=1 and out_last=1.
- Zero count: req1 submits count 0 → req_ready[1] pulses for 1 cycle; no out_valid; pointer moves to 0; busy stays 0.
- Reset mid-job: assert rst while out_data=8 → out_valid, busy and out_data go to 0 immediately. After release, a new req0 job with seeds 1,1 restarts at 1.
